mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter TIMEOUT_W, default 4, width of the memory wait counter; timeout limit is 2^TIMEOUT_W-1 cycles.
REQ-002 Parameter ALUCTR_W, default 4, width of alu_ctr.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 instr  in  32  current instruction register contents (opcode [31:26], funct [5:0]).
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes the current request this cycle.
REQ-008 mem_rd, mem_wr  out  1 each  memory read/write request, held until mem_ready.
REQ-009 i_or_d  out  1  0=PC address, 1=ALU-out address.
REQ-010 ir_wr, pc_wr, pc_wr_cond, reg_wr  out  1 each  write enables.
REQ-011 reg_dst, mem_to_reg, ext_op, alu_src_a  out  1 each  datapath selects; ext_op 1=sign-extend.
REQ-012 alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm16, 11=ext imm16<<2.
REQ-013 pc_src  out  2  00=ALU result, 01=ALU-out register (branch target), 10=jump target {PC[31:28],instr[25:0],2'b00}.
REQ-014 alu_ctr  out  ALUCTR_W  0010 add, 0110 sub, 0001 or, 1010 lui, 0000 pass.
REQ-015 instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-016 bus_err  out  1  sticky memory-timeout flag.
REQ-017 illegal  out  1  sticky illegal-instruction flag (macro-dependent, REQ-031).

Function
REQ-018 Supported ops SHALL be: R-type addu (funct 100001)/subu (100011), lw 100011, sw 101011, beq 000100, ori 001101, j 000010, lui 001111.
REQ-019 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, HALT.
REQ-020 FETCH: mem_rd=1, i_or_d=0; in the cycle mem_ready=1 also ir_wr=1, pc_wr=1, alu_src_a=0, alu_src_b=01, alu_ctr=add, pc_src=00, then go to DECODE; otherwise stay.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctr=add; next = MEM_ADDR (lw/sw), EXEC_R (R), EXEC_I (ori/lui), BRANCH (beq), JUMP (j); unknown opcode per REQ-031.
REQ-022 MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, add; next MEM_RD (lw) or MEM_WR (sw).
REQ-023 MEM_RD: mem_rd=1, i_or_d=1; on mem_ready go to MEM_WB. MEM_WB: reg_wr=1, reg_dst=0, mem_to_reg=1, instr_done=1, go to FETCH.
REQ-024 MEM_WR: mem_wr=1, i_or_d=1; on mem_ready instr_done=1, go to FETCH.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctr from funct. EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctr or (ori) / lui (lui). Both go to ALU_WB.
REQ-026 ALU_WB: reg_wr=1, mem_to_reg=0, reg_dst=1 for R-type else 0, instr_done=1, go to FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_wr_cond=1, pc_src=01, instr_done=1, go to FETCH. JUMP: pc_wr=1, pc_src=10, instr_done=1, go to FETCH.
REQ-028 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle mem_ready=0 there; on reaching 2^TIMEOUT_W-1 with mem_ready still 0, set bus_err and enter HALT.
REQ-029 mem_ready=1 in the same cycle the counter hits the limit SHALL complete normally (no bus_err).
REQ-030 HALT: all enables/requests 0; stays until reset. Signals not listed for a state SHALL be 0. Unlisted ext_op/alu_ctr SHALL be 0.

Configuration
REQ-031 Macro MC_CTRL_ILLEGAL_TRAP_EN: defined -> unknown opcode or R funct not addu/subu sets illegal and enters HALT from DECODE; undefined -> unknown opcode goes to FETCH with instr_done=1 (NOP), any non-addu R funct executes as subu, illegal tied 0.

Reset
REQ-032 While rst_n=0 all outputs SHALL be 0, state=FETCH, counter=0, bus_err=illegal=0; first fetch request in the first cycle after release.
REQ-033 Reset asserted mid-instruction SHALL abort immediately with no further write enable.

Structure
REQ-034 Package mc_ctrl_pkg SHALL hold opcode/funct constants, alu_ctr codes, alu_src_b/pc_src codes and the state enum.
REQ-035 Sub-module mc_ctrl_dec (combinational opcode/funct -> instruction class, alu_ctr, legal) SHALL be instantiated once.

Verification
REQ-036 addu $3,$1,$2 (0x00221821), mem_ready=1 -> 4 cycles FETCH/DECODE/EXEC_R/ALU_WB, reg_wr=1 reg_dst=1 alu_ctr=0010 in cycle 4, instr_done once.
REQ-037 lw (0x8C220004), mem_ready low 3 cycles in MEM_RD -> mem_rd held 4 cycles, MEM_WB with mem_to_reg=1; total 8 cycles.
REQ-038 beq (0x10220003), zero=1 -> BRANCH with pc_wr_cond=1, pc_src=01, alu_ctr=0110; j (0x08000010) -> pc_wr=1 pc_src=10.
REQ-039 TIMEOUT_W=4, mem_ready held 0 in FETCH -> bus_err=1 after 15 cycles, HALT, outputs 0 until rst_n low.
REQ-040 opcode 111111 -> with macro illegal=1 and HALT; without macro NOP, instr_done pulse, next FETCH.
REQ-041 rst_n low during MEM_WR wait -> mem_wr drops same cycle; after release FETCH with mem_rd=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle controller: opcode and funct
// constants, ALU operation codes, alu_src_b / pc_src select codes, the FSM
// state enum, the instruction-class enum produced by the decoder and the
// packed bundle of datapath control outputs.
// No ports (package).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_PASS = 4'b0000;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ORI,
        CLS_LUI,
        CLS_J,
        CLS_BAD
    } instr_class_e;

    // Everything the FSM drives towards the datapath, kept as one bundle so
    // that it can be cleared with a single default and gated during reset.
    typedef struct packed {
        logic       memRd;
        logic       memWr;
        logic       iOrD;
        logic       irWr;
        logic       pcWr;
        logic       pcWrCond;
        logic       regWr;
        logic       regDst;
        logic       memToReg;
        logic       extOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [3:0] aluCtr;
        logic       instrDone;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Bundle between the multi-cycle controller and its datapath / memory.
// Parameter ALUCTR_W : width of alu_ctr.
// Signals:
//   instr[31:0], zero, mem_ready               datapath -> controller
//   mem_rd, mem_wr, i_or_d                     memory request and address select
//   ir_wr, pc_wr, pc_wr_cond, reg_wr           write enables
//   reg_dst, mem_to_reg, ext_op, alu_src_a     datapath selects
//   alu_src_b[1:0], pc_src[1:0], alu_ctr       datapath selects / ALU op
//   instr_done, bus_err, illegal               status
// Modports: master (controller side), slave (datapath side).
// -----------------------------------------------------------------------------
interface mc_ctrl_if #(
    parameter int ALUCTR_W = 4
);

    logic [31:0]         instr;
    logic                zero;
    logic                mem_ready;
    logic                mem_rd;
    logic                mem_wr;
    logic                i_or_d;
    logic                ir_wr;
    logic                pc_wr;
    logic                pc_wr_cond;
    logic                reg_wr;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                ext_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_src;
    logic [ALUCTR_W-1:0] alu_ctr;
    logic                instr_done;
    logic                bus_err;
    logic                illegal;

    modport master (
        input  instr, zero, mem_ready,
        output mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, pc_wr_cond, reg_wr,
               reg_dst, mem_to_reg, ext_op, alu_src_a, alu_src_b, pc_src,
               alu_ctr, instr_done, bus_err, illegal
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, pc_wr_cond, reg_wr,
               reg_dst, mem_to_reg, ext_op, alu_src_a, alu_src_b, pc_src,
               alu_ctr, instr_done, bus_err, illegal
    );

endinterface

// File: rtl/mc_ctrl_dec.sv
// -----------------------------------------------------------------------------
// mc_ctrl_dec
// Purely combinational instruction decoder for the multi-cycle controller.
// Ports:
//   opcode_i[5:0]  instruction opcode field
//   funct_i[5:0]   R-type function field
//   class_o        instruction class used for FSM sequencing
//   aluCtr_o[3:0]  ALU operation for the execute state (R-type and ori/lui)
//   legal_o        1 when the instruction is one the controller implements
// Configuration macro: MC_CTRL_ILLEGAL_TRAP_EN -- when defined, an R-type
// funct other than addu/subu is reported illegal; otherwise it runs as subu.
// -----------------------------------------------------------------------------
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e class_o,
    output logic [3:0]   aluCtr_o,
    output logic         legal_o
);

    // Map opcode/funct to a class and execute-stage ALU code. Unknown
    // opcodes fall into CLS_BAD and are always flagged not legal; what the
    // FSM does with that depends on the trap build option.
    always_comb begin
        class_o  = CLS_BAD;
        aluCtr_o = ALU_PASS;
        legal_o  = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                class_o = CLS_R;
                if (funct_i == FUNCT_ADDU) begin
                    aluCtr_o = ALU_ADD;
                end else if (funct_i == FUNCT_SUBU) begin
                    aluCtr_o = ALU_SUB;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    legal_o  = 1'b0;
`else
                    aluCtr_o = ALU_SUB;
`endif
                end
            end
            OP_LW:  class_o = CLS_LW;
            OP_SW:  class_o = CLS_SW;
            OP_BEQ: class_o = CLS_BEQ;
            OP_J:   class_o = CLS_J;
            OP_ORI: begin
                class_o  = CLS_ORI;
                aluCtr_o = ALU_OR;
            end
            OP_LUI: begin
                class_o  = CLS_LUI;
                aluCtr_o = ALU_LUI;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle MIPS-subset control unit (addu, subu, lw, sw, beq, ori, j, lui).
// Parameters:
//   TIMEOUT_W : width of the memory wait counter; a request that sees no
//               mem_ready for 2^TIMEOUT_W-1 cycles raises bus_err and halts.
//   ALUCTR_W  : width of alu_ctr.
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_io : mc_ctrl_if.master bundle (instr/zero/mem_ready in, all
//            datapath controls, instr_done, bus_err, illegal out)
// Configuration macro: MC_CTRL_ILLEGAL_TRAP_EN -- when defined, unknown
// opcodes and unsupported R-type funct codes set the sticky illegal flag and
// halt; when undefined, unknown opcodes retire as a NOP and illegal is 0.
// -----------------------------------------------------------------------------
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4,
    parameter int ALUCTR_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_ctrl_if.master    bus_io
);

    // Last counter value at which a miss still counts as waiting; a miss
    // seen here is the (2^TIMEOUT_W-1)-th and times out.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] waitCnt_q, waitCnt_d;
    logic                 busErr_q, busErr_d;
    logic                 waitExpired;
    instr_class_e         instrClass;
    logic [3:0]           aluCtrExec;
    logic                 instrLegal;
    ctrl_t                ctrl;
    ctrl_t                ctrlOut;
    logic                 unusedInputs;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic                 illegal_q, illegal_d;
`endif

    mc_ctrl_dec uDec (
        .opcode_i (bus_io.instr[31:26]),
        .funct_i  (bus_io.instr[5:0]),
        .class_o  (instrClass),
        .aluCtr_o (aluCtrExec),
        .legal_o  (instrLegal)
    );

    // The branch condition and the register/immediate fields are consumed
    // directly by the datapath; the controller never looks at them.
    assign unusedInputs = ^{bus_io.zero, bus_io.instr[25:6]};

    assign waitExpired = (waitCnt_q == WAIT_LAST);

    // State, wait counter and sticky error flags. Reset puts the machine
    // straight back into FETCH with a cleared counter, which is also what
    // aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            waitCnt_q <= '0;
            busErr_q  <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            busErr_q  <= busErr_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next state and control outputs. Everything defaults to 0 and the wait
    // counter defaults to clear, so it only holds a count while the FSM sits
    // in one of the three memory-wait states; leaving any state therefore
    // enters the next one with a zero count.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = '0;
        busErr_d  = busErr_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        ctrl      = '0;

        case (state_q)
            S_FETCH: begin
                ctrl.memRd = 1'b1;
                if (bus_io.mem_ready) begin
                    ctrl.irWr    = 1'b1;
                    ctrl.pcWr    = 1'b1;
                    ctrl.aluSrcB = SRCB_FOUR;
                    ctrl.aluCtr  = ALU_ADD;
                    ctrl.pcSrc   = PCSRC_ALU;
                    state_d      = S_DECODE;
                end else if (waitExpired) begin
                    busErr_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    waitCnt_d = waitCnt_q + TIMEOUT_W'(1);
                end
            end

            S_DECODE: begin
                ctrl.aluSrcB = SRCB_IMM_SH2;
                ctrl.extOp   = 1'b1;
                ctrl.aluCtr  = ALU_ADD;
                if (!instrLegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`else
                    ctrl.instrDone = 1'b1;
                    state_d        = S_FETCH;
`endif
                end else begin
                    case (instrClass)
                        CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
                        CLS_R:            state_d = S_EXEC_R;
                        CLS_ORI, CLS_LUI: state_d = S_EXEC_I;
                        CLS_BEQ:          state_d = S_BRANCH;
                        CLS_J:            state_d = S_JUMP;
                        default:          state_d = S_FETCH;
                    endcase
                end
            end

            S_MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.extOp   = 1'b1;
                ctrl.aluCtr  = ALU_ADD;
                state_d      = (instrClass == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                ctrl.memRd = 1'b1;
                ctrl.iOrD  = 1'b1;
                if (bus_io.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (waitExpired) begin
                    busErr_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    waitCnt_d = waitCnt_q + TIMEOUT_W'(1);
                end
            end

            S_MEM_WB: begin
                ctrl.regWr     = 1'b1;
                ctrl.memToReg  = 1'b1;
                ctrl.instrDone = 1'b1;
                state_d        = S_FETCH;
            end

            S_MEM_WR: begin
                ctrl.memWr = 1'b1;
                ctrl.iOrD  = 1'b1;
                if (bus_io.mem_ready) begin
                    ctrl.instrDone = 1'b1;
                    state_d        = S_FETCH;
                end else if (waitExpired) begin
                    busErr_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    waitCnt_d = waitCnt_q + TIMEOUT_W'(1);
                end
            end

            S_EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluCtr  = aluCtrExec;
                state_d      = S_ALU_WB;
            end

            S_EXEC_I: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluCtr  = aluCtrExec;
                state_d      = S_ALU_WB;
            end

            S_ALU_WB: begin
                ctrl.regWr     = 1'b1;
                ctrl.regDst    = (instrClass == CLS_R);
                ctrl.instrDone = 1'b1;
                state_d        = S_FETCH;
            end

            S_BRANCH: begin
                ctrl.aluSrcA   = 1'b1;
                ctrl.aluSrcB   = SRCB_REG;
                ctrl.aluCtr    = ALU_SUB;
                ctrl.pcWrCond  = 1'b1;
                ctrl.pcSrc     = PCSRC_ALUOUT;
                ctrl.instrDone = 1'b1;
                state_d        = S_FETCH;
            end

            S_JUMP: begin
                ctrl.pcWr      = 1'b1;
                ctrl.pcSrc     = PCSRC_JUMP;
                ctrl.instrDone = 1'b1;
                state_d        = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    // FETCH is the reset state and it requests memory, so the decoded
    // controls are forced low combinationally while rst_n is held; this is
    // also what kills a write enable in the same cycle reset arrives.
    assign ctrlOut = rst_n ? ctrl : '0;

    assign bus_io.mem_rd     = ctrlOut.memRd;
    assign bus_io.mem_wr     = ctrlOut.memWr;
    assign bus_io.i_or_d     = ctrlOut.iOrD;
    assign bus_io.ir_wr      = ctrlOut.irWr;
    assign bus_io.pc_wr      = ctrlOut.pcWr;
    assign bus_io.pc_wr_cond = ctrlOut.pcWrCond;
    assign bus_io.reg_wr     = ctrlOut.regWr;
    assign bus_io.reg_dst    = ctrlOut.regDst;
    assign bus_io.mem_to_reg = ctrlOut.memToReg;
    assign bus_io.ext_op     = ctrlOut.extOp;
    assign bus_io.alu_src_a  = ctrlOut.aluSrcA;
    assign bus_io.alu_src_b  = ctrlOut.aluSrcB;
    assign bus_io.pc_src     = ctrlOut.pcSrc;
    assign bus_io.alu_ctr    = ALUCTR_W'(ctrlOut.aluCtr);
    assign bus_io.instr_done = ctrlOut.instrDone;
    assign bus_io.bus_err    = rst_n & busErr_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus_io.illegal    = rst_n & illegal_q;
`else
    assign bus_io.illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Directed self-checking bench for mc_ctrl. Each cycle drives instr /
// mem_ready / zero and compares every controller output, packed into one
// vector, against a hand-written expected vector.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    // Observed vector layout:
    // [21] mem_rd [20] mem_wr [19] i_or_d [18] ir_wr [17] pc_wr
    // [16] pc_wr_cond [15] reg_wr [14] reg_dst [13] mem_to_reg [12] ext_op
    // [11] alu_src_a [10:9] alu_src_b [8:7] pc_src [6:3] alu_ctr
    // [2] instr_done [1] bus_err [0] illegal
    localparam logic [21:0] MEMRD    = 22'b1 << 21;
    localparam logic [21:0] MEMWR    = 22'b1 << 20;
    localparam logic [21:0] IORD     = 22'b1 << 19;
    localparam logic [21:0] IRWR     = 22'b1 << 18;
    localparam logic [21:0] PCWR     = 22'b1 << 17;
    localparam logic [21:0] PCWRC    = 22'b1 << 16;
    localparam logic [21:0] REGWR    = 22'b1 << 15;
    localparam logic [21:0] REGDST   = 22'b1 << 14;
    localparam logic [21:0] MEM2REG  = 22'b1 << 13;
    localparam logic [21:0] EXTOP    = 22'b1 << 12;
    localparam logic [21:0] SRCA     = 22'b1 << 11;
    localparam logic [21:0] SB_FOUR  = 22'd1 << 9;
    localparam logic [21:0] SB_IMM   = 22'd2 << 9;
    localparam logic [21:0] SB_SH2   = 22'd3 << 9;
    localparam logic [21:0] PC_AOUT  = 22'd1 << 7;
    localparam logic [21:0] PC_JUMP  = 22'd2 << 7;
    localparam logic [21:0] A_ADD    = 22'd2 << 3;
    localparam logic [21:0] A_SUB    = 22'd6 << 3;
    localparam logic [21:0] A_OR     = 22'd1 << 3;
    localparam logic [21:0] A_LUI    = 22'd10 << 3;
    localparam logic [21:0] DONE     = 22'b1 << 2;
    localparam logic [21:0] BUSERR   = 22'b1 << 1;
    localparam logic [21:0] ILLEGAL  = 22'b1;

    // Per-state expected vectors
    localparam logic [21:0] X_FWAIT  = MEMRD;
    localparam logic [21:0] X_FETCH  = MEMRD | IRWR | PCWR | SB_FOUR | A_ADD;
    localparam logic [21:0] X_DEC    = SB_SH2 | EXTOP | A_ADD;
    localparam logic [21:0] X_MADDR  = SRCA | SB_IMM | EXTOP | A_ADD;
    localparam logic [21:0] X_MRD    = MEMRD | IORD;
    localparam logic [21:0] X_MWB    = REGWR | MEM2REG | DONE;
    localparam logic [21:0] X_MWR    = MEMWR | IORD;
    localparam logic [21:0] X_ADDU   = SRCA | A_ADD;
    localparam logic [21:0] X_SUBU   = SRCA | A_SUB;
    localparam logic [21:0] X_ORI    = SRCA | SB_IMM | A_OR;
    localparam logic [21:0] X_LUI    = SRCA | SB_IMM | A_LUI;
    localparam logic [21:0] X_RWB    = REGWR | REGDST | DONE;
    localparam logic [21:0] X_IWB    = REGWR | DONE;
    localparam logic [21:0] X_BR     = SRCA | A_SUB | PCWRC | PC_AOUT | DONE;
    localparam logic [21:0] X_JMP    = PCWR | PC_JUMP | DONE;

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_SUBU = 32'h00221823;
    localparam logic [31:0] I_BADF = 32'h00221820;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ORI  = 32'h34220005;
    localparam logic [31:0] I_LUI  = 32'h3C011234;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;
    logic [21:0] obsVec;
    int          compareCount  = 0;
    int          mismatchCount = 0;

    mc_ctrl_if #(.ALUCTR_W(4)) bus ();

    mc_ctrl #(
        .TIMEOUT_W (4),
        .ALUCTR_W  (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rstN),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    assign obsVec = {bus.mem_rd, bus.mem_wr, bus.i_or_d, bus.ir_wr, bus.pc_wr,
                     bus.pc_wr_cond, bus.reg_wr, bus.reg_dst, bus.mem_to_reg,
                     bus.ext_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                     bus.alu_ctr, bus.instr_done, bus.bus_err, bus.illegal};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [21:0] observed,
                               input logic [21:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %06h expected %06h", tag, observed, expected);
        end
    endtask

    // One controller cycle: called #1 after a rising edge, drives the inputs,
    // checks the settled outputs, then moves to #1 after the next edge.
    task automatic applyStimulus(input string tag, input logic [31:0] instrV,
                                 input logic readyV, input logic zeroV,
                                 input logic [21:0] expV);
        bus.instr     = instrV;
        bus.mem_ready = readyV;
        bus.zero      = zeroV;
        #1;
        checkOutput(tag, obsVec, expV);
        @(posedge clk);
        #1;
    endtask

    // Assert reset part-way through a cycle, check outputs drop at once,
    // hold it across an edge, then release it #1 after the edge.
    task automatic midCycleReset(input string tag);
        rstN = 1'b0;
        #1;
        checkOutput({tag, ".drop"}, obsVec, 22'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".held"}, obsVec, 22'd0);
        rstN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.instr     = I_ADDU;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset.held0", obsVec, 22'd0);
        @(posedge clk);
        #1;
        checkOutput("reset.held1", obsVec, 22'd0);
        rstN = 1'b1;

        $display("[TB] addu");
        applyStimulus("addu.fetch",  I_ADDU, 1'b1, 1'b0, X_FETCH);
        applyStimulus("addu.decode", I_ADDU, 1'b1, 1'b0, X_DEC);
        applyStimulus("addu.exec",   I_ADDU, 1'b1, 1'b0, X_ADDU);
        applyStimulus("addu.wb",     I_ADDU, 1'b1, 1'b0, X_RWB);

        $display("[TB] lw with three wait cycles");
        applyStimulus("lw.fetch",  I_LW, 1'b1, 1'b0, X_FETCH);
        applyStimulus("lw.decode", I_LW, 1'b1, 1'b0, X_DEC);
        applyStimulus("lw.addr",   I_LW, 1'b1, 1'b0, X_MADDR);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("lw.wait%0d", i), I_LW, 1'b0, 1'b0, X_MRD);
        applyStimulus("lw.rdready", I_LW, 1'b1, 1'b0, X_MRD);
        applyStimulus("lw.wb",      I_LW, 1'b1, 1'b0, X_MWB);

        $display("[TB] subu");
        applyStimulus("subu.fetch",  I_SUBU, 1'b1, 1'b0, X_FETCH);
        applyStimulus("subu.decode", I_SUBU, 1'b1, 1'b0, X_DEC);
        applyStimulus("subu.exec",   I_SUBU, 1'b1, 1'b0, X_SUBU);
        applyStimulus("subu.wb",     I_SUBU, 1'b1, 1'b0, X_RWB);

        $display("[TB] sw");
        applyStimulus("sw.fetch",  I_SW, 1'b1, 1'b0, X_FETCH);
        applyStimulus("sw.decode", I_SW, 1'b1, 1'b0, X_DEC);
        applyStimulus("sw.addr",   I_SW, 1'b1, 1'b0, X_MADDR);
        applyStimulus("sw.wait",   I_SW, 1'b0, 1'b0, X_MWR);
        applyStimulus("sw.done",   I_SW, 1'b1, 1'b0, X_MWR | DONE);

        $display("[TB] beq and j");
        applyStimulus("beq.fetch",  I_BEQ, 1'b1, 1'b1, X_FETCH);
        applyStimulus("beq.decode", I_BEQ, 1'b1, 1'b1, X_DEC);
        applyStimulus("beq.branch", I_BEQ, 1'b1, 1'b1, X_BR);
        applyStimulus("j.fetch",    I_J,   1'b1, 1'b0, X_FETCH);
        applyStimulus("j.decode",   I_J,   1'b1, 1'b0, X_DEC);
        applyStimulus("j.jump",     I_J,   1'b1, 1'b0, X_JMP);

        $display("[TB] ori and lui");
        applyStimulus("ori.fetch",  I_ORI, 1'b1, 1'b0, X_FETCH);
        applyStimulus("ori.decode", I_ORI, 1'b1, 1'b0, X_DEC);
        applyStimulus("ori.exec",   I_ORI, 1'b1, 1'b0, X_ORI);
        applyStimulus("ori.wb",     I_ORI, 1'b1, 1'b0, X_IWB);
        applyStimulus("lui.fetch",  I_LUI, 1'b1, 1'b0, X_FETCH);
        applyStimulus("lui.decode", I_LUI, 1'b1, 1'b0, X_DEC);
        applyStimulus("lui.exec",   I_LUI, 1'b1, 1'b0, X_LUI);
        applyStimulus("lui.wb",     I_LUI, 1'b1, 1'b0, X_IWB);

        // mem_ready arriving on the last permitted wait cycle completes.
        $display("[TB] fetch ready on the limit cycle");
        for (int i = 0; i < 14; i++)
            applyStimulus($sformatf("edge.wait%0d", i), I_J, 1'b0, 1'b0, X_FWAIT);
        applyStimulus("edge.ready",  I_J, 1'b1, 1'b0, X_FETCH);
        applyStimulus("edge.decode", I_J, 1'b1, 1'b0, X_DEC);
        applyStimulus("edge.jump",   I_J, 1'b1, 1'b0, X_JMP);

        $display("[TB] reset during MEM_WR wait");
        applyStimulus("rst.fetch",  I_SW, 1'b1, 1'b0, X_FETCH);
        applyStimulus("rst.decode", I_SW, 1'b1, 1'b0, X_DEC);
        applyStimulus("rst.addr",   I_SW, 1'b1, 1'b0, X_MADDR);
        bus.mem_ready = 1'b0;
        #1;
        checkOutput("rst.memwr", obsVec, X_MWR);
        midCycleReset("rst");
        applyStimulus("rst.refetch", I_ADDU, 1'b0, 1'b0, X_FWAIT);
        applyStimulus("rst.fetch2",  I_ADDU, 1'b1, 1'b0, X_FETCH);
        applyStimulus("rst.decode2", I_ADDU, 1'b1, 1'b0, X_DEC);
        applyStimulus("rst.exec2",   I_ADDU, 1'b1, 1'b0, X_ADDU);
        applyStimulus("rst.wb2",     I_ADDU, 1'b1, 1'b0, X_RWB);

        $display("[TB] unknown opcode and unsupported funct");
        applyStimulus("ill.fetch", I_ILL, 1'b1, 1'b0, X_FETCH);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        applyStimulus("ill.decode", I_ILL, 1'b1, 1'b0, X_DEC);
        applyStimulus("ill.halt0",  I_ILL, 1'b1, 1'b0, ILLEGAL);
        applyStimulus("ill.halt1",  I_ADDU, 1'b1, 1'b0, ILLEGAL);
        midCycleReset("ill.rst");
        applyStimulus("badf.fetch",  I_BADF, 1'b1, 1'b0, X_FETCH);
        applyStimulus("badf.decode", I_BADF, 1'b1, 1'b0, X_DEC);
        applyStimulus("badf.halt",   I_BADF, 1'b1, 1'b0, ILLEGAL);
        midCycleReset("badf.rst");
`else
        applyStimulus("ill.decode", I_ILL, 1'b1, 1'b0, X_DEC | DONE);
        applyStimulus("ill.next",   I_ILL, 1'b0, 1'b0, X_FWAIT);
        applyStimulus("ill.fetch2", I_BADF, 1'b1, 1'b0, X_FETCH);
        applyStimulus("badf.decode", I_BADF, 1'b1, 1'b0, X_DEC);
        applyStimulus("badf.exec",   I_BADF, 1'b1, 1'b0, X_SUBU);
        applyStimulus("badf.wb",     I_BADF, 1'b1, 1'b0, X_RWB);
`endif

        // Fifteen missed cycles in FETCH time out into HALT with bus_err.
        $display("[TB] fetch timeout");
        for (int i = 0; i < 15; i++)
            applyStimulus($sformatf("tmo.wait%0d", i), I_ADDU, 1'b0, 1'b0, X_FWAIT);
        applyStimulus("tmo.halt0", I_ADDU, 1'b0, 1'b0, BUSERR);
        applyStimulus("tmo.halt1", I_ADDU, 1'b1, 1'b0, BUSERR);
        applyStimulus("tmo.halt2", I_LW,   1'b1, 1'b0, BUSERR);
        midCycleReset("tmo.rst");
        applyStimulus("tmo.refetch", I_ADDU, 1'b1, 1'b0, X_FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
